updown_sweep_counter: RTL and testbench

//  Register-programmed up/down sweep counter, next generation of the updowncounter block.

---
 rtl/updown_sweep_counter_if.sv | 15 +
 rtl/updown_sweep_counter.sv | 162 ++++++++++++++++
 tb/tb_updown_sweep_counter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/updown_sweep_counter_if.sv
// Host register bus for the sweep counter: active-low strobes, a 3-bit register select
// and separate write/read data paths.
interface updown_sweep_counter_if #(
    parameter int WIDTH = 8
);
    logic [2:0]       addr;
    logic             ncs;
    logic             nwr;
    logic             nrd;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;

    modport master (output addr, ncs, nwr, nrd, din, input dout);
    modport slave  (input addr, ncs, nwr, nrd, din, output dout);
endinterface

// File: rtl/updown_sweep_counter.sv
// Register-programmed up/down sweep counter: START -> UPPER -> LOWER -> START for NCYC
// sweeps (or forever in continuous mode), with abort, config validation and status readback.
module updown_sweep_counter #(
    parameter int WIDTH = 8,
    parameter int CYC_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    updown_sweep_counter_if.slave  bus,
    input  logic                   start,
    output logic [WIDTH-1:0]       cout,
    output logic                   dir,
    output logic                   ec,
    output logic                   err,
    output logic                   busy
);
    localparam logic [2:0] A_START  = 3'd0;
    localparam logic [2:0] A_UPPER  = 3'd1;
    localparam logic [2:0] A_LOWER  = 3'd2;
    localparam logic [2:0] A_NCYC   = 3'd3;
    localparam logic [2:0] A_CTRL   = 3'd4;
    localparam logic [2:0] A_STATUS = 3'd5;
    localparam logic [2:0] A_SWEEPS = 3'd6;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] start_reg;
    logic [WIDTH-1:0] upper_reg;
    logic [WIDTH-1:0] lower_reg;
    logic [CYC_W-1:0] ncyc_reg;
    logic             cont_reg;
    logic [WIDTH-1:0] cout_reg;
    logic             dir_reg;
    logic             ec_reg;
    logic             err_reg;
    logic             busy_reg;
    logic             aborted_reg;
    logic [CYC_W-1:0] sweeps_reg;

    logic             wr_en;
    logic             rd_en;
    logic             abort_req;
    logic             cfg_valid;
    logic [WIDTH-1:0] cout_next;
    logic             dir_next;
    logic             at_boundary;
    logic [CYC_W-1:0] sweeps_next;

    assign wr_en     = !bus.ncs && !bus.nwr && bus.nrd;
    assign rd_en     = !bus.ncs && !bus.nrd;
    assign abort_req = wr_en && (bus.addr == A_CTRL) && bus.din[1] && (state_reg == S_RUN);
    assign cfg_valid = (lower_reg <= start_reg) && (start_reg < upper_reg)
                       && ((ncyc_reg != '0) || cont_reg);

    // One step of the sweep; the limits guarantee the step never wraps.
    always_comb begin
        cout_next   = dir_reg ? cout_reg + WIDTH'(1) : cout_reg - WIDTH'(1);
        dir_next    = dir_reg;
        if (cout_next == upper_reg) begin
            dir_next = 1'b0;
        end else if (cout_next == lower_reg) begin
            dir_next = 1'b1;
        end
        at_boundary = (cout_next == start_reg) && dir_next;
        sweeps_next = sweeps_reg + CYC_W'(1);
        if (!cont_reg && (sweeps_reg == '1)) begin
            sweeps_next = sweeps_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            start_reg   <= '0;
            upper_reg   <= '0;
            lower_reg   <= '0;
            ncyc_reg    <= '0;
            cont_reg    <= 1'b0;
            cout_reg    <= '0;
            dir_reg     <= 1'b0;
            ec_reg      <= 1'b0;
            err_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            aborted_reg <= 1'b0;
            sweeps_reg  <= '0;
        end else begin
            ec_reg <= 1'b0;

            // Limit registers are frozen while a sweep runs; CTRL stays writable so abort works.
            if (wr_en) begin
                case (bus.addr)
                    A_START: if (state_reg == S_IDLE) start_reg <= bus.din;
                    A_UPPER: if (state_reg == S_IDLE) upper_reg <= bus.din;
                    A_LOWER: if (state_reg == S_IDLE) lower_reg <= bus.din;
                    A_NCYC:  if (state_reg == S_IDLE) ncyc_reg  <= CYC_W'(bus.din);
                    A_CTRL:  cont_reg <= bus.din[0];
                    default: ;
                endcase
            end

            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_valid) begin
                            state_reg   <= S_RUN;
                            cout_reg    <= start_reg;
                            dir_reg     <= 1'b1;
                            busy_reg    <= 1'b1;
                            err_reg     <= 1'b0;
                            aborted_reg <= 1'b0;
                            sweeps_reg  <= '0;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (abort_req) begin
                        state_reg   <= S_IDLE;
                        busy_reg    <= 1'b0;
                        aborted_reg <= 1'b1;
                    end else begin
                        cout_reg <= cout_next;
                        dir_reg  <= dir_next;
                        if (at_boundary) begin
                            sweeps_reg <= sweeps_next;
                            if (!cont_reg && (sweeps_next == ncyc_reg)) begin
                                ec_reg    <= 1'b1;
                                busy_reg  <= 1'b0;
                                state_reg <= S_IDLE;
                            end
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.dout = '0;
        if (rd_en) begin
            case (bus.addr)
                A_START:  bus.dout = start_reg;
                A_UPPER:  bus.dout = upper_reg;
                A_LOWER:  bus.dout = lower_reg;
                A_NCYC:   bus.dout = WIDTH'(ncyc_reg);
                A_CTRL:   bus.dout = WIDTH'(cont_reg);
                A_STATUS: bus.dout = WIDTH'({aborted_reg, busy_reg, err_reg, dir_reg});
                A_SWEEPS: bus.dout = WIDTH'(sweeps_reg);
                default:  bus.dout = '0;
            endcase
        end
    end

    assign cout = cout_reg;
    assign dir  = dir_reg;
    assign ec   = ec_reg;
    assign err  = err_reg;
    assign busy = busy_reg;
endmodule

// File: tb/tb_updown_sweep_counter.sv
// Scoreboard bench: expected (cout, dir, ec) triples are queued from the programmed limits
// and popped one per clock edge; a 12-bit instance covers the wide full-range sweep.
module tb_updown_sweep_counter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    updown_sweep_counter_if #(.WIDTH(8))  bus8 ();
    updown_sweep_counter_if #(.WIDTH(12)) bus12 ();

    logic       start8 = 1'b0;
    logic [7:0] cout8;
    logic       dir8, ec8, err8, busy8;

    logic        start12 = 1'b0;
    logic [11:0] cout12;
    logic        dir12, ec12, err12, busy12;

    updown_sweep_counter #(.WIDTH(8), .CYC_W(8)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8), .start(start8),
        .cout(cout8), .dir(dir8), .ec(ec8), .err(err8), .busy(busy8)
    );

    updown_sweep_counter #(.WIDTH(12), .CYC_W(8)) dut12 (
        .clk(clk), .rst(rst), .bus(bus12), .start(start12),
        .cout(cout12), .dir(dir12), .ec(ec12), .err(err12), .busy(busy12)
    );

    typedef struct packed {
        logic [7:0] cout;
        logic       dir;
        logic       ec;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    int   n_cmp = 0;
    int   n_err = 0;
    int   inj_idx = -1;
    logic [2:0] inj_addr = '0;
    logic [7:0] inj_data = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Expected trace: the START load, then each sweep up to UPPER, down to LOWER, back to START.
    function automatic void push_sweeps(input int s, input int u, input int l, input int n,
                                        input bit cont);
        exp_t e;
        e = '{cout: 8'(s), dir: 1'b1, ec: 1'b0};
        exp_q.push_back(e);
        for (int k = 0; k < n; k++) begin
            for (int v = s + 1; v <= u; v++) exp_q.push_back('{8'(v), (v != u), 1'b0});
            for (int v = u - 1; v >= l; v--) exp_q.push_back('{8'(v), (v == l), 1'b0});
            for (int v = l + 1; v <= s; v++) exp_q.push_back('{8'(v), 1'b1, 1'b0});
        end
        if (!cont) begin
            e = exp_q.pop_back();
            e.ec = 1'b1;
            exp_q.push_back(e);
        end
    endfunction

    task automatic wr8(input logic [2:0] a, input logic [7:0] d);
        bus8.addr = a; bus8.din = d; bus8.ncs = 1'b0; bus8.nwr = 1'b0;
        @(posedge clk); #1;
        bus8.ncs = 1'b1; bus8.nwr = 1'b1;
    endtask

    task automatic wr12(input logic [2:0] a, input logic [11:0] d);
        bus12.addr = a; bus12.din = d; bus12.ncs = 1'b0; bus12.nwr = 1'b0;
        @(posedge clk); #1;
        bus12.ncs = 1'b1; bus12.nwr = 1'b1;
    endtask

    task automatic rd8(input logic [2:0] a, output logic [7:0] d);
        bus8.addr = a; bus8.ncs = 1'b0; bus8.nrd = 1'b0;
        #1;
        d = bus8.dout;
        bus8.ncs = 1'b1; bus8.nrd = 1'b1;
        #1;
    endtask

    task automatic program8(input logic [7:0] s, input logic [7:0] u, input logic [7:0] l,
                            input logic [7:0] n);
        wr8(3'd0, s); wr8(3'd1, u); wr8(3'd2, l); wr8(3'd3, n);
    endtask

    // Pops n_pop expected entries, one per edge; start is held for the first edge only.
    task automatic run_check(input int n_pop);
        exp_t e;
        for (int i = 0; i < n_pop; i++) begin
            if (exp_q.size() == 0) begin
                check("queue_underflow", 32'(i), 32'(n_pop));
                return;
            end
            if (i == inj_idx) begin
                bus8.addr = inj_addr; bus8.din = inj_data; bus8.ncs = 1'b0; bus8.nwr = 1'b0;
            end
            @(posedge clk); #1;
            start8 = 1'b0;
            bus8.ncs = 1'b1; bus8.nwr = 1'b1;
            e = exp_q.pop_front();
            last_exp = e;
            $display("txn %0d: cout=%0d dir=%0b ec=%0b (exp %0d/%0b/%0b)",
                     i, cout8, dir8, ec8, e.cout, e.dir, e.ec);
            check("cout", 32'(cout8), 32'(e.cout));
            check("dir", 32'(dir8), 32'(e.dir));
            check("ec", 32'(ec8), 32'(e.ec));
        end
    endtask

    logic [7:0]  rdata;
    logic [11:0] maxv, minv;
    int          edges, ec_cnt;
    bit          done12;

    initial begin
        bus8.ncs = 1'b1; bus8.nwr = 1'b1; bus8.nrd = 1'b1; bus8.addr = '0; bus8.din = '0;
        bus12.ncs = 1'b1; bus12.nwr = 1'b1; bus12.nrd = 1'b1; bus12.addr = '0; bus12.din = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_cout", 32'(cout8), 32'd0);
        check("rst_dir", 32'(dir8), 32'd0);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_err", 32'(err8), 32'd0);
        check("rst_ec", 32'(ec8), 32'd0);
        rd8(3'd1, rdata); check("rst_upper", 32'(rdata), 32'd0);
        rd8(3'd5, rdata); check("rst_status", 32'(rdata), 32'd0);

        // 1: two short sweeps
        program8(8'd3, 8'd4, 8'd2, 8'd2);
        check("dout_idle", 32'(bus8.dout), 32'd0);
        push_sweeps(3, 4, 2, 2, 1'b0);
        start8 = 1'b1;
        run_check(exp_q.size());
        check("t1_busy", 32'(busy8), 32'd0);
        rd8(3'd6, rdata); check("t1_sweeps", 32'(rdata), 32'd2);
        @(posedge clk); #1;
        check("t1_ec_once", 32'(ec8), 32'd0);
        check("t1_hold", 32'(cout8), 32'd3);

        // 2: START on LOWER
        program8(8'd2, 8'd5, 8'd2, 8'd1);
        push_sweeps(2, 5, 2, 1, 1'b0);
        start8 = 1'b1;
        run_check(exp_q.size());

        // 3: invalid config then recovery
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        program8(8'd5, 8'd5, 8'd1, 8'd1);
        start8 = 1'b1; @(posedge clk); #1; start8 = 1'b0;
        check("t3_err", 32'(err8), 32'd1);
        check("t3_busy", 32'(busy8), 32'd0);
        check("t3_cout", 32'(cout8), 32'd0);
        rd8(3'd5, rdata); check("t3_status", 32'(rdata), 32'h2);
        wr8(3'd0, 8'd2);
        push_sweeps(2, 5, 1, 1, 1'b0);
        start8 = 1'b1;
        run_check(1);
        check("t3_err_clear", 32'(err8), 32'd0);
        check("t3_busy_run", 32'(busy8), 32'd1);
        run_check(exp_q.size());

        // 4: continuous mode, 20 edges, then abort
        wr8(3'd4, 8'h1);
        program8(8'd1, 8'd3, 8'd0, 8'd0);
        push_sweeps(1, 3, 0, 4, 1'b1);
        start8 = 1'b1;
        run_check(21);
        exp_q.delete();
        wr8(3'd4, 8'h2);
        check("t4_freeze_cout", 32'(cout8), 32'(last_exp.cout));
        check("t4_freeze_dir", 32'(dir8), 32'(last_exp.dir));
        check("t4_busy", 32'(busy8), 32'd0);
        check("t4_ec", 32'(ec8), 32'd0);
        rd8(3'd5, rdata); check("t4_aborted", 32'(rdata[3]), 32'd1);
        rd8(3'd6, rdata); check("t4_sweeps", 32'(rdata), 32'd3);
        repeat (3) @(posedge clk);
        #1;
        check("t4_still_frozen", 32'(cout8), 32'(last_exp.cout));
        check("t4_ec_late", 32'(ec8), 32'd0);

        // 5: mid-run write to UPPER is ignored; then reset mid-run
        program8(8'd3, 8'd4, 8'd2, 8'd2);
        push_sweeps(3, 4, 2, 2, 1'b0);
        inj_idx = 3; inj_addr = 3'd1; inj_data = 8'd9;
        start8 = 1'b1;
        run_check(exp_q.size());
        inj_idx = -1;
        rd8(3'd1, rdata); check("t5_upper", 32'(rdata), 32'd4);
        push_sweeps(3, 4, 2, 2, 1'b0);
        start8 = 1'b1;
        run_check(4);
        exp_q.delete();
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        check("t5_rst_cout", 32'(cout8), 32'd0);
        check("t5_rst_busy", 32'(busy8), 32'd0);
        check("t5_rst_dir", 32'(dir8), 32'd0);
        rd8(3'd0, rdata); check("t5_rst_start", 32'(rdata), 32'd0);
        rd8(3'd6, rdata); check("t5_rst_sweeps", 32'(rdata), 32'd0);

        // 6: 12-bit full-range sweep
        wr12(3'd0, 12'h7FE); wr12(3'd1, 12'hFFF); wr12(3'd2, 12'h000); wr12(3'd3, 12'd1);
        start12 = 1'b1; @(posedge clk); #1; start12 = 1'b0;
        check("t6_load", 32'(cout12), 32'h7FE);
        maxv = cout12; minv = cout12; edges = 0; ec_cnt = 0; done12 = 1'b0;
        while (!done12 && edges < 9000) begin
            @(posedge clk); #1;
            edges++;
            if (cout12 > maxv) maxv = cout12;
            if (cout12 < minv) minv = cout12;
            if (ec12) begin
                ec_cnt++;
                done12 = 1'b1;
            end
        end
        $display("t6: %0d edges, max=%0h min=%0h", edges, maxv, minv);
        check("t6_edges", 32'(edges), 32'd8190);
        check("t6_max", 32'(maxv), 32'hFFF);
        check("t6_min", 32'(minv), 32'h0);
        check("t6_end_cout", 32'(cout12), 32'h7FE);
        check("t6_busy", 32'(busy12), 32'd0);
        repeat (4) begin
            @(posedge clk); #1;
            if (ec12) ec_cnt++;
        end
        check("t6_ec_count", 32'(ec_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
